// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared constants and helpers for the multi-width SPI slave
//                bridge: mode encodings, edge-role constants, defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int DEF_WORD_W      = 8;
    localparam int DEF_SYNC_STAGES = 2;

    // {cpol, cpha}
    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_e;

    localparam logic EDGE_RISE = 1'b1;
    localparam logic EDGE_FALL = 1'b0;

    // Sample edge is the rising one exactly when cpol equals cpha
    // (mode 0 samples on the leading rise, mode 3 on the trailing rise).
    function automatic logic sample_edge(input logic [1:0] i_mode);
        return (i_mode[1] == i_mode[0]) ? EDGE_RISE : EDGE_FALL;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sync
//  Description : Generic STAGES-deep single-bit synchroniser with a
//                selectable reset value.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // Shift the asynchronous input through the flop chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= {STAGES{RST_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spi_bridge_mw.sv
`default_nettype none
// ============================================================================
//  Module      : spi_bridge_mw
//  Description : Oversampled SPI slave bridge with configurable word width,
//                runtime-selectable SPI mode, selectable shift order, TX
//                reload handshake and partial-frame error detection.
//                Optional macro SPI_BRIDGE_MISO_OE_EN adds a miso_oe output
//                and gates miso low while it is inactive.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_bridge_mw import spi_pkg::*; #(
    parameter int WORD_W      = DEF_WORD_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int LSB_FIRST   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    input  logic [1:0]        mode,
    output logic              word_sync,
    output logic [WORD_W-1:0] data_in,
    input  logic [WORD_W-1:0] data_out,
    output logic              tx_load,
    output logic              frame_err,
`ifdef SPI_BRIDGE_MISO_OE_EN
    output logic              miso_oe,
`endif
    output logic              busy
);

    localparam int                CNT_W  = $clog2(WORD_W);
    localparam logic [CNT_W-1:0]  c_LAST = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0]  c_ONE  = CNT_W'(1);

    logic w_sclk_s, w_cs_s, w_mosi_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .i_d(sclk), .o_q(w_sclk_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .i_d(cs_n), .o_q(w_cs_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .i_d(mosi), .o_q(w_mosi_s));

    logic                   r_sclk_d;
    logic                   r_cs_d;
    logic [SYNC_STAGES-1:0] r_settle;
    logic                   r_armed;
    logic [1:0]             r_mode;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [WORD_W-1:0]      r_rx;
    logic [WORD_W-1:0]      r_tx;
    logic                   r_supp;
    logic [WORD_W-1:0]      r_data_in;
    logic                   r_word_sync;
    logic                   r_tx_load;
    logic                   r_frame_err;

    logic [WORD_W-1:0] w_rx_next;
    logic [WORD_W-1:0] w_tx_next;
    logic              w_tx_bit;

    // Shift direction is fixed at elaboration time
    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign w_rx_next = {w_mosi_s, r_rx[WORD_W-1:1]};
            assign w_tx_next = {1'b0, r_tx[WORD_W-1:1]};
            assign w_tx_bit  = r_tx[0];
        end else begin : g_msb_first
            assign w_rx_next = {r_rx[WORD_W-2:0], w_mosi_s};
            assign w_tx_next = {r_tx[WORD_W-2:0], 1'b0};
            assign w_tx_bit  = r_tx[WORD_W-1];
        end
    endgenerate

    logic w_rise, w_fall, w_samp_rise, w_active;
    logic w_cs_assert, w_cs_deassert, w_sample, w_shift, w_busy;

    assign w_rise        = w_sclk_s & ~r_sclk_d;
    assign w_fall        = ~w_sclk_s & r_sclk_d;
    assign w_samp_rise   = (sample_edge(r_mode) == EDGE_RISE);
    // A cs deassertion makes w_cs_s high, so any coincident sclk edge is
    // dropped by w_active.
    assign w_active      = r_armed & ~w_cs_s;
    assign w_cs_assert   = r_armed & r_cs_d & ~w_cs_s;
    assign w_cs_deassert = r_armed & ~r_cs_d & w_cs_s;
    assign w_sample      = w_active & (w_samp_rise ? w_rise : w_fall);
    assign w_shift       = w_active & (w_samp_rise ? w_fall : w_rise);
    assign w_busy        = r_armed & ~w_cs_s;

    // Arming: the synchroniser reset value of cs is not a real observation,
    // so wait until the chain has refilled before trusting a high cs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle <= '0;
            r_armed  <= 1'b0;
            r_sclk_d <= 1'b0;
            r_cs_d   <= 1'b1;
            r_mode   <= '0;
        end else begin
            r_settle <= {r_settle[SYNC_STAGES-2:0], 1'b1};
            r_sclk_d <= w_sclk_s;
            r_cs_d   <= w_cs_s;
            if (r_settle[SYNC_STAGES-1] && w_cs_s) begin
                r_armed <= 1'b1;
            end
            if (w_cs_s) begin
                r_mode <= mode;
            end
        end
    end

    // Frame datapath: RX shift/word capture, TX reload/shift, error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt   <= '0;
            r_rx        <= '0;
            r_tx        <= '0;
            r_supp      <= 1'b0;
            r_data_in   <= '0;
            r_word_sync <= 1'b0;
            r_tx_load   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_word_sync <= 1'b0;
            r_tx_load   <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_cs_s) begin
                r_bit_cnt <= '0;
                r_tx      <= data_out;
                r_supp    <= 1'b0;
                if (w_cs_deassert && (r_bit_cnt != '0)) begin
                    r_frame_err <= 1'b1;
                end
            end else if (w_cs_assert) begin
                r_tx_load <= 1'b1;
                r_supp    <= r_mode[0];
            end else begin
                if (w_sample) begin
                    r_rx <= w_rx_next;
                    if (r_bit_cnt == c_LAST) begin
                        r_bit_cnt   <= '0;
                        r_data_in   <= w_rx_next;
                        r_word_sync <= 1'b1;
                        r_tx        <= data_out;
                        r_tx_load   <= 1'b1;
                        r_supp      <= 1'b1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + c_ONE;
                    end
                end
                if (w_shift) begin
                    if (r_supp) begin
                        r_supp <= 1'b0;
                    end else begin
                        r_tx <= w_tx_next;
                    end
                end
            end
        end
    end

    assign word_sync = r_word_sync;
    assign data_in   = r_data_in;
    assign tx_load   = r_tx_load;
    assign frame_err = r_frame_err;
    assign busy      = w_busy;

`ifdef SPI_BRIDGE_MISO_OE_EN
    assign miso_oe = w_busy;
    assign miso    = w_busy & w_tx_bit;
`else
    assign miso    = w_tx_bit;
`endif

endmodule
`default_nettype wire

// File: doc/spi_bridge_mw.md
Name: spi_bridge_mw

Overview:
- Parametrised successor of the current 8-bit, mode-0-only SPI slave bridge.
- Word width is configurable, and all four SPI modes are runtime-selectable.
- Shift order is selectable (MSB- or LSB-first).
- Adds a TX reload handshake and partial-frame error detection.
- Sits between the external SPI master pins and the register/instruction decoder. All logic runs in the peripheral clock domain; SPI pins are oversampled.

Parameters:
- WORD_W, 8, bits per word; legal range 4..32.
- SYNC_STAGES, 2, synchroniser flops on sclk/cs_n/mosi; legal 2..4.
- LSB_FIRST, 0, 0 = MSB shifted first on both mosi and miso; 1 = LSB first.

Ports:
- clk  in  1  peripheral clock; must be at least 4x the max sclk frequency.
- rst_n  in  1  reset; asynchronous, active-low.
- sclk  in  1  SPI clock from master (asynchronous).
- cs_n  in  1  SPI chip select, active-low (asynchronous).
- mosi  in  1  SPI data from master.
- miso  out  1  SPI data to master.
- mode  in  2  {cpol,cpha}; quasi-static.
- word_sync  out  1  one-clk pulse: data_in holds a new complete word.
- data_in  out  WORD_W  last received word.
- data_out  in  WORD_W  word to transmit.
- tx_load  out  1  one-clk pulse: data_out captured into TX shifter.
- frame_err  out  1  one-clk pulse: cs_n deasserted mid-word.
- busy  out  1  high while frame active (synchronised cs low and armed).

Behaviour:
- Reset values: miso=0, word_sync=0, data_in=0, tx_load=0, frame_err=0, busy=0.
- Reset clears the synchroniser chains: sclk=0, cs=1, mosi=0.
- Synchronisers:
  - SYNC_STAGES flops per input, plus one sclk history flop.
  - Edge detection compares the last stage against the history flop.
  - word_sync, tx_load and frame_err go high exactly one clk after the detecting cycle.
- Mode latch:
  - mode is captured into the active-mode register only while the synchronised cs is inactive.
  - Changes during a frame are ignored until cs deasserts.
- Edge roles:
  - Leading edge = rise if cpol=0, fall if cpol=1.
  - Sample edge = leading if cpha=0, trailing if cpha=1.
  - Shift edge = the other edge.
- Arming:
  - After reset, the bridge is armed only once synchronised cs has been high for at least 1 clk.
  - A frame already in progress at reset release is ignored entirely.
- RX path:
  - Each sample edge shifts the synchronised mosi into the RX shifter and increments bit_cnt (width $clog2(WORD_W)).
  - When bit_cnt reaches WORD_W-1: data_in is updated with the full word including the current bit, word_sync pulses, and bit_cnt wraps to 0.
  - Frames of any word multiple are supported.
- TX path:
  - While cs is inactive, the TX shifter continuously loads data_out.
  - At each word completion, it reloads data_out and pulses tx_load in the same cycle as word_sync.
  - On cs assertion, tx_load pulses once.
  - miso is driven from bit WORD_W-1 if LSB_FIRST=0, or bit 0 if LSB_FIRST=1.
- Shift suppression:
  - A suppress flag is set at every word completion, and at cs assertion when cpha=1.
  - The next shift edge clears the flag without shifting.
  - All other shift edges advance the shifter by one bit (zero fill).
- Frame end:
  - On synchronised cs deassertion, bit_cnt clears to 0.
  - If bit_cnt was nonzero, frame_err pulses, the partial word is discarded, data_in is unchanged, and word_sync does not pulse.
- Simultaneous events:
  - If a cs deassertion and an sclk edge are detected in the same cycle, cs wins and the edge is ignored.
  - If a word completes on the cycle before cs deasserts, the word is valid and frame_err does not pulse.
- Reset mid-frame: all state clears; re-arming rule above applies.

Optional Feature:
- Macro: SPI_BRIDGE_MISO_OE_EN.
- When defined:
  - Adds output miso_oe (1 bit, reset 0), equal to busy, for an external tri-state pad.
  - miso is forced to 0 whenever miso_oe=0.
- When undefined: no miso_oe port; miso always reflects the TX shifter output bit.

Decomposition:
- Package spi_pkg:
  - Mode encodings MODE0..MODE3.
  - Edge-role helper constants.
  - Default WORD_W and SYNC_STAGES.
- Sub-module spi_sync: generic SYNC_STAGES-deep synchroniser with a reset-value parameter, instantiated once per pin (three instances).

Test Plan:
- Mode 0, WORD_W=8, MSB-first, master sends 0xA5 while data_out=0x3C -> word_sync one pulse, data_in=0xA5, master receives 0x3C, frame_err=0.
- Modes 1/2/3, each sending 0x5A then 0xC3 in one cs frame, data_out changed to 0x81 on the first tx_load -> data_in sequence 0x5A, 0xC3; master receives 0x3C, 0x81; two word_sync and two word-completion tx_load pulses.
- WORD_W=16, LSB_FIRST=1, master sends 0x1234 LSB-first -> data_in=0x1234; miso emits data_out LSB first.
- cs_n deasserted after 5 bits of an 8-bit word -> frame_err pulses once, no word_sync, data_in keeps its previous value, next frame receives correctly.
- mode changed from 0 to 3 mid-frame -> current frame completes in mode 0; next frame operates in mode 3.
- rst_n asserted during bit 3 while cs_n stays low, then released -> no word_sync until cs_n goes high then low; the following 0xFF is received correctly; all outputs read their reset values during reset.
